vproc_div_result_fifo: RTL and testbench

// - Result queue directly downstream of the vector divide unit. Captures {ctrl, result, byte mask} beats

---
 rtl/vproc_div_result_fifo.sv | 170 +++++++++++++++++
 tb/tb_vproc_div_result_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_div_result_fifo.sv
// Result queue between the vector divide unit and the register writeback stage.
// Holds {ctrl, result, byte mask} beats in strict FIFO order, with no fall-through,
// and pulses instr_done_o when the last beat of an instruction leaves the queue.

package vproc_div_result_fifo_pkg;

  // Default pipeline control type; any replacement must also carry last_cycle.
  typedef struct packed {
    logic [7:0] tag;
    logic       last_cycle;
  } div_ctrl_t;

endpackage

module vproc_div_result_fifo #(
  parameter int  DIV_OP_W = 64,
  parameter int  DEPTH    = 2,
  parameter type CTRL_T   = vproc_div_result_fifo_pkg::div_ctrl_t
) (
  input  logic                       clk_i,
  input  logic                       sync_rst_i,

  input  logic                       pipe_in_valid_i,
  output logic                       pipe_in_ready_o,
  input  CTRL_T                      pipe_in_ctrl_i,
  input  logic [DIV_OP_W-1:0]        pipe_in_res_i,
  input  logic [DIV_OP_W/8-1:0]      pipe_in_mask_i,

  output logic                       pipe_out_valid_o,
  input  logic                       pipe_out_ready_i,
  output CTRL_T                      pipe_out_ctrl_o,
  output logic [DIV_OP_W-1:0]        pipe_out_res_o,
  output logic [DIV_OP_W/8-1:0]      pipe_out_mask_o,

  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       instr_done_o
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int MASK_W = DIV_OP_W / 8;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // Entry storage: deliberately left out of reset, only pointers and count are cleared.
  CTRL_T               ctrl_mem [DEPTH];
  logic [DIV_OP_W-1:0] res_mem  [DEPTH];
  logic [MASK_W-1:0]   mask_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Handshake qualifiers: both sides look only at the registered count, so a pop
  // never frees a slot for a push in the same cycle.
  always_comb begin
    full             = (count_reg == FULL_CNT);
    empty            = (count_reg == '0);
    pipe_in_ready_o  = ~full;
    pipe_out_valid_o = ~empty;
    push             = pipe_in_valid_i & pipe_in_ready_o;
    pop              = pipe_out_valid_o & pipe_out_ready_i;
  end

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointer and count registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // One write port per entry, selected by the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic wr_sel;

    // Decode of the write pointer for this slot.
    always_comb begin
      wr_sel = push && (wr_ptr_reg == PTR_W'(gi));
    end

    // Capture the incoming beat into this slot.
    always_ff @(posedge clk_i) begin
      if (wr_sel && !sync_rst_i) begin
        ctrl_mem[gi] <= pipe_in_ctrl_i;
        res_mem[gi]  <= pipe_in_res_i;
        mask_mem[gi] <= pipe_in_mask_i;
      end
    end
  end

  // Head presentation: forced to zero while empty so stale masks never reach writeback.
  always_comb begin
    pipe_out_ctrl_o = '0;
    pipe_out_res_o  = '0;
    pipe_out_mask_o = '0;
    if (pipe_out_valid_o) begin
      pipe_out_ctrl_o = ctrl_mem[rd_ptr_reg];
      pipe_out_res_o  = res_mem[rd_ptr_reg];
      pipe_out_mask_o = mask_mem[rd_ptr_reg];
    end
  end

  // Completion pulse for the final beat of an instruction leaving the queue.
  always_comb begin
    instr_done_o = pop & pipe_out_ctrl_o.last_cycle;
    count_o      = count_reg;
  end

`ifndef SYNTHESIS
  logic in_pending_reg;

  // Remember a beat that was offered but not taken, to check the producer holds it.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      in_pending_reg <= 1'b0;
    end else begin
      in_pending_reg <= pipe_in_valid_i & ~pipe_in_ready_o;
    end
  end

  // Protocol sanity checks at every active edge outside reset.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      assert (!(push && full))
        else $error("div_result_fifo: push while full");
      assert (!(pop && empty))
        else $error("div_result_fifo: pop while empty");
      if (in_pending_reg) begin
        assert (pipe_in_valid_i)
          else $error("div_result_fifo: valid_i dropped before acceptance");
      end
    end
  end
`endif

endmodule

// File: tb/tb_vproc_div_result_fifo.sv
// Directed bench for the divider result queue (DIV_OP_W=64, DEPTH=2).
// Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.

module tb_vproc_div_result_fifo;

  import vproc_div_result_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        in_valid;
  logic        in_ready;
  div_ctrl_t   in_ctrl;
  logic [63:0] in_res;
  logic [7:0]  in_mask;
  logic        out_valid;
  logic        out_ready;
  div_ctrl_t   out_ctrl;
  logic [63:0] out_res;
  logic [7:0]  out_mask;
  logic [1:0]  count;
  logic        instr_done;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RES_P = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RES_A = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] RES_B = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] RES_C = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] RES_D = 64'hDDDD_0000_0000_000D;
  localparam logic [63:0] RES_E = 64'hEEEE_0000_0000_000E;
  localparam logic [63:0] RES_F = 64'hFFFF_0000_0000_000F;
  localparam logic [63:0] RES_G = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] RES_H = 64'h5555_0000_0000_0005;
  localparam logic [63:0] RES_I = 64'h6666_0000_0000_0006;
  localparam logic [63:0] RES_J = 64'h7777_0000_0000_0007;

  always #5 clk = ~clk;

  vproc_div_result_fifo #(
    .DIV_OP_W (64),
    .DEPTH    (2),
    .CTRL_T   (div_ctrl_t)
  ) dut (
    .clk_i            (clk),
    .sync_rst_i       (sync_rst),
    .pipe_in_valid_i  (in_valid),
    .pipe_in_ready_o  (in_ready),
    .pipe_in_ctrl_i   (in_ctrl),
    .pipe_in_res_i    (in_res),
    .pipe_in_mask_i   (in_mask),
    .pipe_out_valid_o (out_valid),
    .pipe_out_ready_i (out_ready),
    .pipe_out_ctrl_o  (out_ctrl),
    .pipe_out_res_o   (out_res),
    .pipe_out_mask_o  (out_mask),
    .count_o          (count),
    .instr_done_o     (instr_done)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
    $display("check %-22s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic [7:0] m,
                       input logic [7:0] tag, input logic last);
    in_valid           = v;
    in_res             = r;
    in_mask            = m;
    in_ctrl.tag        = tag;
    in_ctrl.last_cycle = last;
  endtask

  initial begin
    sync_rst  = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    tick();
    sync_rst = 1'b0;
    tick();
    settle();

    // Reset then idle
    chk("rst_count",     64'(count),      64'd0);
    chk("rst_valid",     64'(out_valid),  64'd0);
    chk("rst_ready",     64'(in_ready),   64'd1);
    chk("rst_res",       out_res,         64'd0);
    chk("rst_mask",      64'(out_mask),   64'd0);
    chk("rst_ctrl",      64'(out_ctrl),   64'd0);
    chk("rst_done",      64'(instr_done), 64'd0);

    // Single beat, no fall-through
    out_ready = 1'b1;
    drive(1'b1, RES_P, 8'hFF, 8'h01, 1'b0);
    settle();
    chk("p_no_fallthru", 64'(out_valid),  64'd0);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    settle();
    chk("p_valid",       64'(out_valid),  64'd1);
    chk("p_res",         out_res,         RES_P);
    chk("p_mask",        64'(out_mask),   64'hFF);
    chk("p_count1",      64'(count),      64'd1);
    tick();
    settle();
    chk("p_count0",      64'(count),      64'd0);
    chk("p_valid0",      64'(out_valid),  64'd0);
    chk("p_res_zero",    out_res,         64'd0);

    // Back-pressure: A,B fill the queue, C stalls
    out_ready = 1'b0;
    drive(1'b1, RES_A, 8'h01, 8'h0A, 1'b0);
    tick();
    drive(1'b1, RES_B, 8'h02, 8'h0B, 1'b0);
    settle();
    chk("abc_count1",    64'(count),      64'd1);
    tick();
    drive(1'b1, RES_C, 8'h04, 8'h0C, 1'b0);
    settle();
    chk("abc_count2",    64'(count),      64'd2);
    chk("abc_ready0",    64'(in_ready),   64'd0);
    tick();
    settle();
    chk("abc_stall_cnt", 64'(count),      64'd2);
    chk("abc_head_a",    out_res,         RES_A);
    out_ready = 1'b1;
    settle();
    chk("abc_pop_a",     out_res,         RES_A);
    chk("abc_ready_full",64'(in_ready),   64'd0);
    tick();
    settle();
    chk("abc_head_b",    out_res,         RES_B);
    chk("abc_cnt_after", 64'(count),      64'd1);
    chk("abc_ready1",    64'(in_ready),   64'd1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    settle();
    chk("abc_head_c",    out_res,         RES_C);
    chk("abc_mask_c",    64'(out_mask),   64'h04);
    chk("abc_cnt_c",     64'(count),      64'd1);
    tick();
    settle();
    chk("abc_drained",   64'(count),      64'd0);

    // Full queue, pop and offered push in the same cycle: 2 -> 1 -> 2
    out_ready = 1'b0;
    drive(1'b1, RES_D, 8'h10, 8'h0D, 1'b0);
    tick();
    drive(1'b1, RES_E, 8'h20, 8'h0E, 1'b0);
    tick();
    drive(1'b1, RES_F, 8'h40, 8'h0F, 1'b0);
    out_ready = 1'b1;
    settle();
    chk("full_cnt2",     64'(count),      64'd2);
    tick();
    out_ready = 1'b0;
    settle();
    chk("full_cnt1",     64'(count),      64'd1);
    chk("full_head_e",   out_res,         RES_E);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    settle();
    chk("full_cnt2b",    64'(count),      64'd2);
    chk("full_ready0",   64'(in_ready),   64'd0);
    out_ready = 1'b1;
    tick();
    settle();
    chk("full_head_f",   out_res,         RES_F);
    tick();
    settle();
    chk("full_drained",  64'(count),      64'd0);

    // last_cycle beat produces a single-cycle instr_done pulse
    out_ready = 1'b0;
    drive(1'b1, RES_G, 8'h0F, 8'h55, 1'b1);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0);
    settle();
    chk("done_held_lo",  64'(instr_done), 64'd0);
    chk("done_mask",     64'(out_mask),   64'h0F);
    out_ready = 1'b1;
    settle();
    chk("done_pulse",    64'(instr_done), 64'd1);
    chk("done_ctrl_last",64'(out_ctrl.last_cycle), 64'd1);
    chk("done_res",      out_res,         RES_G);
    tick();
    settle();
    chk("done_fall",     64'(instr_done), 64'd0);
    chk("done_valid0",   64'(out_valid),  64'd0);

    // Reset mid-stream with a full queue and active handshakes
    out_ready = 1'b0;
    drive(1'b1, RES_H, 8'h11, 8'h05, 1'b0);
    tick();
    drive(1'b1, RES_I, 8'h22, 8'h06, 1'b1);
    tick();
    settle();
    chk("mrst_full",     64'(count),      64'd2);
    sync_rst  = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, RES_J, 8'h33, 8'h07, 1'b0);
    tick();
    sync_rst = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    settle();
    chk("mrst_count",    64'(count),      64'd0);
    chk("mrst_valid",    64'(out_valid),  64'd0);
    chk("mrst_res",      out_res,         64'd0);
    chk("mrst_done",     64'(instr_done), 64'd0);
    tick();
    settle();
    chk("mrst_quiet_v",  64'(out_valid),  64'd0);
    chk("mrst_quiet_c",  64'(count),      64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
